// File: rtl/fwd_dest_pipe_pkg.sv
// fwd_dest_pipe_pkg
//   Shared definitions for the destination-index pipeline and the ALU
//   operand-forwarding select logic.
//   - REG_ADDR_W_DEF / ZERO_REG_DEF : default register-index width and the
//     hardwired-zero register index.
//   - fwd_sel_e : 3:1 forwarding mux select codes, in the order the muxes
//     decode them (00 register file, 01 MEM/WB, 10 EX/MEM).
package fwd_dest_pipe_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG_DEF   = 0;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_dest_pipe_sel.sv
// fwd_sel_logic
//   Combinational forwarding-select generator for one ALU operand.
//   Ports:
//     src_i      : EX-stage source register index of the operand
//     mem_dest_i : EX/MEM destination index
//     mem_wr_i   : EX/MEM register-file write enable
//     wb_dest_i  : MEM/WB destination index
//     wb_wr_i    : MEM/WB register-file write enable
//     sel_o      : mux select (00 regfile, 01 MEM/WB, 10 EX/MEM; never 11)
module fwd_sel_logic
  import fwd_dest_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned ZERO_REG   = ZERO_REG_DEF
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  input  logic                  mem_wr_i,
  input  logic [REG_ADDR_W-1:0] wb_dest_i,
  input  logic                  wb_wr_i,
  output logic [1:0]            sel_o
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  fwd_sel_e sel;

  // EX/MEM is checked first: it holds the newest value of the register.
  always_comb begin
    sel = FWD_REGFILE;
    if (mem_wr_i && (mem_dest_i != ZERO_IDX) && (mem_dest_i == src_i)) begin
      sel = FWD_MEM;
    end else if (wb_wr_i && (wb_dest_i != ZERO_IDX) && (wb_dest_i == src_i)) begin
      sel = FWD_WB;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/fwd_dest_pipe.sv
// fwd_dest_pipe
//   Carries the EX-stage destination register index through the EX/MEM and
//   MEM/WB pipeline registers, generates the ALU operand-forwarding mux
//   selects from the carried indices and raises the ID load-use stall.
//   Ports:
//     clk, rst_n        : clock (rising edge), asynchronous active-low reset
//     stall             : hold every pipeline register
//     flush             : turn the instruction entering MEM into a bubble
//     ex_dest_reg       : destination index from the EX destination mux
//     ex_reg_write      : EX instruction writes the register file
//     ex_mem_read       : EX instruction is a load
//     ex_rs, ex_rt      : EX operand source indices
//     id_rs, id_rt      : ID operand source indices
//     fwd_a_sel         : operand A select (00 regfile, 01 MEM/WB, 10 EX/MEM)
//     fwd_b_sel         : operand B select, same encoding
//     load_use_stall    : ID must hold and bubble EX
//     mem_dest_reg, mem_reg_write : EX/MEM stage contents
//     wb_dest_reg,  wb_reg_write  : MEM/WB stage contents (regfile write port)
module fwd_dest_pipe
  import fwd_dest_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned ZERO_REG   = ZERO_REG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  load_use_stall,
  output logic [REG_ADDR_W-1:0] mem_dest_reg,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] wb_dest_reg,
  output logic                  wb_reg_write
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic                  mem_wr_q,   mem_wr_d;
  logic [REG_ADDR_W-1:0] wb_dest_q,  wb_dest_d;
  logic                  wb_wr_q,    wb_wr_d;

  // The load flag of the MEM-stage instruction is not carried: forwarding
  // from EX/MEM is encoded identically for loads, and the load-use hazard is
  // resolved from the EX-stage flag before the load ever reaches MEM.

  // Stall outranks flush; a flush seen during a stall is dropped.
  always_comb begin
    mem_dest_d = mem_dest_q;
    mem_wr_d   = mem_wr_q;
    wb_dest_d  = wb_dest_q;
    wb_wr_d    = wb_wr_q;
    if (!stall) begin
      wb_dest_d = mem_dest_q;
      wb_wr_d   = mem_wr_q;
      if (flush) begin
        mem_dest_d = '0;
        mem_wr_d   = 1'b0;
      end else begin
        mem_dest_d = ex_dest_reg;
        mem_wr_d   = ex_reg_write;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dest_q <= '0;
      mem_wr_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_wr_q    <= 1'b0;
    end else begin
      mem_dest_q <= mem_dest_d;
      mem_wr_q   <= mem_wr_d;
      wb_dest_q  <= wb_dest_d;
      wb_wr_q    <= wb_wr_d;
    end
  end

  assign mem_dest_reg  = mem_dest_q;
  assign mem_reg_write = mem_wr_q;
  assign wb_dest_reg   = wb_dest_q;
  assign wb_reg_write  = wb_wr_q;

  fwd_sel_logic #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_fwd_a (
    .src_i      (ex_rs),
    .mem_dest_i (mem_dest_q),
    .mem_wr_i   (mem_wr_q),
    .wb_dest_i  (wb_dest_q),
    .wb_wr_i    (wb_wr_q),
    .sel_o      (fwd_a_sel)
  );

  fwd_sel_logic #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_fwd_b (
    .src_i      (ex_rt),
    .mem_dest_i (mem_dest_q),
    .mem_wr_i   (mem_wr_q),
    .wb_dest_i  (wb_dest_q),
    .wb_wr_i    (wb_wr_q),
    .sel_o      (fwd_b_sel)
  );

  assign load_use_stall = ex_mem_read && ex_reg_write && (ex_dest_reg != ZERO_IDX) &&
                          ((ex_dest_reg == id_rs) || (ex_dest_reg == id_rt));

endmodule

// File: tb/tb_fwd_dest_pipe.sv
module tb_fwd_dest_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flush;
  logic [4:0] ex_dest_reg;
  logic       ex_reg_write, ex_mem_read;
  logic [4:0] ex_rs, ex_rt, id_rs, id_rt;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       load_use_stall;
  logic [4:0] mem_dest_reg, wb_dest_reg;
  logic       mem_reg_write, wb_reg_write;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: the two in-flight instructions as plain integers.
  int m_dest, m_wr, w_dest, w_wr;

  always #5 clk = ~clk;

  fwd_dest_pipe #(
    .REG_ADDR_W (5),
    .ZERO_REG   (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .ex_dest_reg    (ex_dest_reg),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .load_use_stall (load_use_stall),
    .mem_dest_reg   (mem_dest_reg),
    .mem_reg_write  (mem_reg_write),
    .wb_dest_reg    (wb_dest_reg),
    .wb_reg_write   (wb_reg_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sel(input int src);
    if (m_wr != 0 && m_dest != 0 && m_dest == src) return 2;
    if (w_wr != 0 && w_dest != 0 && w_dest == src) return 1;
    return 0;
  endfunction

  function automatic int model_lus();
    int d;
    d = int'(ex_dest_reg);
    return (ex_mem_read && ex_reg_write && d != 0 &&
            (d == int'(id_rs) || d == int'(id_rt))) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_dest = 0; m_wr = 0; w_dest = 0; w_wr = 0;
  endtask

  task automatic drive(input int dest, input int wr, input int rd, input int rs,
                       input int rt, input int irs, input int irt,
                       input int st, input int fl);
    ex_dest_reg  = 5'(dest);
    ex_reg_write = wr[0];
    ex_mem_read  = rd[0];
    ex_rs        = 5'(rs);
    ex_rt        = 5'(rt);
    id_rs        = 5'(irs);
    id_rt        = 5'(irt);
    stall        = st[0];
    flush        = fl[0];
  endtask

  // Clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!stall) begin
      w_dest = m_dest;
      w_wr   = m_wr;
      if (flush) begin
        m_dest = 0;
        m_wr   = 0;
      end else begin
        m_dest = int'(ex_dest_reg);
        m_wr   = int'(ex_reg_write);
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(model_sel(int'(ex_rs))));
    check({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(model_sel(int'(ex_rt))));
    check({tag, ".lus"},   32'(load_use_stall), 32'(model_lus()));
    check({tag, ".mdest"}, 32'(mem_dest_reg), 32'(m_dest));
    check({tag, ".mwr"},   32'(mem_reg_write), 32'(m_wr));
    check({tag, ".wdest"}, 32'(wb_dest_reg), 32'(w_dest));
    check({tag, ".wwr"},   32'(wb_reg_write), 32'(w_wr));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Mid-stream asynchronous reset with r7 in EX/MEM.
    drive(7, 1, 0, 7, 7, 0, 0, 0, 0);
    tick();
    check_all("pre_rst");
    check("pre_rst.mdest7", 32'(mem_dest_reg), 32'd7);
    check("pre_rst.fwd_a10", 32'(fwd_a_sel), 32'd2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.mwr", 32'(mem_reg_write), 32'd0);
    check("async_rst.wwr", 32'(wb_reg_write), 32'd0);
    check("async_rst.fwd_a", 32'(fwd_a_sel), 32'd0);
    check("async_rst.fwd_b", 32'(fwd_b_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: r5 forwarded from MEM, then WB, then regfile.
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
    check_all("b2b0");
    check("b2b.mem", 32'(fwd_a_sel), 32'd2);
    tick();
    check_all("b2b1");
    check("b2b.wb", 32'(fwd_a_sel), 32'd1);
    tick();
    check_all("b2b2");
    check("b2b.rf", 32'(fwd_a_sel), 32'd0);

    // r9 in both stages: EX/MEM wins; r0 never forwarded.
    drive(9, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 9, 0, 0, 0, 0);
    check_all("prio");
    check("prio.mem", 32'(fwd_b_sel), 32'd2);
    ex_rt = 5'd0;
    check_all("prio0");
    check("prio.zero", 32'(fwd_b_sel), 32'd0);

    // Load-use detection.
    drive(3, 1, 1, 0, 0, 3, 0, 0, 0);
    check_all("lu_rs");
    check("lu.rs", 32'(load_use_stall), 32'd1);
    drive(3, 1, 1, 0, 0, 4, 3, 0, 0);
    check_all("lu_rt");
    check("lu.rt", 32'(load_use_stall), 32'd1);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    check_all("lu_r0");
    check("lu.r0", 32'(load_use_stall), 32'd0);

    // Stall holds for three edges, then the pipe advances.
    drive(12, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(20, 1, 0, 12, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall");
      check("stall.mdest", 32'(mem_dest_reg), 32'd12);
    end
    stall = 1'b0;
    tick();
    check_all("unstall");
    check("unstall.mdest", 32'(mem_dest_reg), 32'd20);
    check("unstall.wdest", 32'(wb_dest_reg), 32'd12);

    // Flush bubbles MEM; flush with stall is ignored.
    drive(8, 1, 0, 8, 0, 0, 0, 0, 1);
    tick();
    check_all("flush");
    check("flush.mwr", 32'(mem_reg_write), 32'd0);
    check("flush.mdest", 32'(mem_dest_reg), 32'd0);
    check("flush.wdest", 32'(wb_dest_reg), 32'd20);
    check("flush.fwd_a", 32'(fwd_a_sel), 32'd0);
    drive(11, 1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    check_all("flush_stall");
    check("flush_stall.wdest", 32'(wb_dest_reg), 32'd20);

    // Randomized traffic over a small index range to provoke hits.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0);
      check_all("rnd");
      tick();
    end
    check_all("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
